// File: rtl/btn_debounce.sv
// Pushbutton debouncer: a four-state qualifier that accepts a level change only
// after DB_CYCLES consecutive equal samples, with registered level, strobes and press count.
module btn_debounce #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sync_in,
  output logic       db_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [2:0] press_cnt
);

  // The counter only ever needs to reach DB_CYCLES-1, so the top of the legal range still fits.
  generate
    if (DB_CYCLES < 2 || DB_CYCLES > (2 ** CNT_W)) begin : g_bad_param
      $error("btn_debounce: DB_CYCLES out of range for CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CHK_HI = 2'b01,
    HIGH   = 2'b10,
    CHK_LO = 2'b11
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             db_level_nxt;
  logic             press_pulse_nxt;
  logic             release_pulse_nxt;
  logic [2:0]       press_cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      db_level      <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_cnt     <= 3'd0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      db_level      <= db_level_nxt;
      press_pulse   <= press_pulse_nxt;
      release_pulse <= release_pulse_nxt;
      press_cnt     <= press_cnt_nxt;
    end
  end

  // Strobes default low so each is high only for the cycle after its accepting edge.
  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    db_level_nxt      = db_level;
    press_pulse_nxt   = 1'b0;
    release_pulse_nxt = 1'b0;
    press_cnt_nxt     = press_cnt;

    unique case (state)
      IDLE: begin
        if (sync_in) begin
          state_nxt = CHK_HI;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end

      CHK_HI: begin
        if (!sync_in) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt       = HIGH;
          cnt_nxt         = '0;
          db_level_nxt    = 1'b1;
          press_pulse_nxt = 1'b1;
          press_cnt_nxt   = press_cnt + 3'd1;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end

      HIGH: begin
        if (!sync_in) begin
          state_nxt = CHK_LO;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end

      CHK_LO: begin
        if (sync_in) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt         = IDLE;
          cnt_nxt           = '0;
          db_level_nxt      = 1'b0;
          release_pulse_nxt = 1'b1;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end

      default: begin
        state_nxt    = IDLE;
        cnt_nxt      = '0;
        db_level_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce at DB_CYCLES=4: clean press/release, glitches,
// release bounce, press counter wrap, reset during qualification and stuck-high input.
module tb_btn_debounce;

  logic       clk;
  logic       rst_n;
  logic       sync_in;
  logic       db_level;
  logic       press_pulse;
  logic       release_pulse;
  logic [2:0] press_cnt;

  int vectors;
  int miscompares;
  logic [2:0] exp_cnt;

  btn_debounce #(
    .DB_CYCLES(4),
    .CNT_W    (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sync_in      (sync_in),
    .db_level     (db_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .press_cnt    (press_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle so outputs reflect that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    sync_in = 1'b1;
    step();
    step();
    vectors++;
    if ({db_level, press_pulse, release_pulse, press_cnt} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_state: got lvl=%b pp=%b rp=%b cnt=%0d, want all 0",
               db_level, press_pulse, release_pulse, press_cnt);
    end
    sync_in = 1'b0;
    rst_n   = 1'b1;
    step();
    exp_cnt = 3'd0;
  endtask

  task automatic test_clean_press();
    sync_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 4) exp_cnt = exp_cnt + 3'd1;
      vectors++;
      if (press_pulse !== (i == 4) || db_level !== (i >= 4) ||
          release_pulse !== 1'b0 || press_cnt !== exp_cnt) begin
        miscompares++;
        $display("FAIL clean_press[%0d]: got pp=%b lvl=%b rp=%b cnt=%0d, want pp=%b lvl=%b rp=0 cnt=%0d",
                 i, press_pulse, db_level, release_pulse, press_cnt,
                 (i == 4), (i >= 4), exp_cnt);
      end
    end
    sync_in = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      vectors++;
      if (release_pulse !== (i == 4) || db_level !== (i < 4) ||
          press_pulse !== 1'b0 || press_cnt !== exp_cnt) begin
        miscompares++;
        $display("FAIL clean_release[%0d]: got rp=%b lvl=%b pp=%b cnt=%0d, want rp=%b lvl=%b pp=0 cnt=%0d",
                 i, release_pulse, db_level, press_pulse, press_cnt,
                 (i == 4), (i < 4), exp_cnt);
      end
    end
  endtask

  task automatic test_rise_glitch();
    for (int i = 1; i <= 9; i++) begin
      sync_in = (i <= 3);
      step();
      vectors++;
      if (press_pulse !== 1'b0 || db_level !== 1'b0 || press_cnt !== exp_cnt) begin
        miscompares++;
        $display("FAIL rise_glitch[%0d]: got pp=%b lvl=%b cnt=%0d, want pp=0 lvl=0 cnt=%0d",
                 i, press_pulse, db_level, press_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_release_bounce();
    logic [6:0] pattern;
    sync_in = 1'b1;
    for (int i = 0; i < 6; i++) step();
    exp_cnt = exp_cnt + 3'd1;
    vectors++;
    if (db_level !== 1'b1 || press_cnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL bounce_setup: got lvl=%b cnt=%0d, want lvl=1 cnt=%0d",
               db_level, press_cnt, exp_cnt);
    end
    // low, low, high, low, low, low, low (bit 0 applied first)
    pattern = 7'b0000100;
    for (int i = 0; i < 7; i++) begin
      sync_in = pattern[i];
      step();
      vectors++;
      if (release_pulse !== (i == 6) || db_level !== (i != 6) || press_pulse !== 1'b0) begin
        miscompares++;
        $display("FAIL release_bounce[%0d]: got rp=%b lvl=%b pp=%b, want rp=%b lvl=%b pp=0",
                 i, release_pulse, db_level, press_pulse, (i == 6), (i != 6));
      end
    end
    step();
    vectors++;
    if (release_pulse !== 1'b0 || db_level !== 1'b0) begin
      miscompares++;
      $display("FAIL release_bounce_after: got rp=%b lvl=%b, want rp=0 lvl=0",
               release_pulse, db_level);
    end
  endtask

  task automatic test_wrap();
    logic [2:0] want;
    rst_n = 1'b0;
    sync_in = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      want = 3'((k + 1) % 8);
      sync_in = 1'b1;
      for (int i = 0; i < 4; i++) step();
      vectors++;
      if (press_pulse !== 1'b1 || press_cnt !== want) begin
        miscompares++;
        $display("FAIL wrap[%0d]: got pp=%b cnt=%0d, want pp=1 cnt=%0d",
                 k, press_pulse, press_cnt, want);
      end
      sync_in = 1'b0;
      for (int i = 0; i < 5; i++) step();
    end
    exp_cnt = 3'd1;
  endtask

  task automatic test_reset_mid();
    sync_in = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    step();
    vectors++;
    if ({db_level, press_pulse, release_pulse, press_cnt} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got lvl=%b pp=%b rp=%b cnt=%0d, want all 0",
               db_level, press_pulse, release_pulse, press_cnt);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      vectors++;
      if (press_pulse !== (i == 4) || db_level !== (i >= 4) ||
          press_cnt !== ((i >= 4) ? 3'd1 : 3'd0)) begin
        miscompares++;
        $display("FAIL reset_release[%0d]: got pp=%b lvl=%b cnt=%0d, want pp=%b lvl=%b cnt=%0d",
                 i, press_pulse, db_level, press_cnt, (i == 4), (i >= 4), (i >= 4) ? 1 : 0);
      end
    end
    // Reset landing on the accepting edge must discard the press entirely.
    rst_n = 1'b0;
    sync_in = 1'b0;
    step();
    rst_n = 1'b1;
    sync_in = 1'b1;
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b0;
    step();
    vectors++;
    if ({db_level, press_pulse, release_pulse, press_cnt} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_pending: got lvl=%b pp=%b rp=%b cnt=%0d, want all 0",
               db_level, press_pulse, release_pulse, press_cnt);
    end
    rst_n = 1'b1;
    sync_in = 1'b0;
    step();
    exp_cnt = 3'd0;
  endtask

  task automatic test_stuck_high();
    int n_press;
    int n_rel;
    int n_both;
    n_press = 0;
    n_rel   = 0;
    n_both  = 0;
    sync_in = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (press_pulse === 1'b1) n_press++;
      if (release_pulse === 1'b1) n_rel++;
      if (press_pulse === 1'b1 && release_pulse === 1'b1) n_both++;
    end
    exp_cnt = exp_cnt + 3'd1;
    vectors++;
    if (n_press != 1 || n_rel != 0 || n_both != 0) begin
      miscompares++;
      $display("FAIL stuck_high: got presses=%0d releases=%0d both=%0d, want 1 0 0",
               n_press, n_rel, n_both);
    end
    vectors++;
    if (db_level !== 1'b1 || press_cnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL stuck_high_level: got lvl=%b cnt=%0d, want lvl=1 cnt=%0d",
               db_level, press_cnt, exp_cnt);
    end
    sync_in = 1'b0;
    for (int i = 0; i < 6; i++) step();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_cnt     = 3'd0;
    rst_n       = 1'b0;
    sync_in     = 1'b0;
    test_reset();
    test_clean_press();
    test_rise_glitch();
    test_release_bounce();
    test_wrap();
    test_reset_mid();
    test_stuck_high();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter DB_CYCLES, default 16: number of consecutive equal samples required to accept a level change; legal range 2..(2**CNT_W).
REQ-002 Parameter CNT_W, default 5: debounce counter width in bits.
REQ-003 Port clk, input, 1: rising-edge clock for all state.
REQ-004 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 Port sync_in, input, 1: already-synchronized pushbutton level from the double-DFF synchronizer; 1 = pressed.
REQ-006 Port db_level, output, 1: debounced button level; 1 = pressed.
REQ-007 Port press_pulse, output, 1: one-cycle strobe on each accepted press.
REQ-008 Port release_pulse, output, 1: one-cycle strobe on each accepted release.
REQ-009 Port press_cnt, output, 3: running count of accepted presses.
REQ-010 All outputs SHALL be driven directly from registers, with no combinational path from sync_in.

Function
REQ-011 The FSM SHALL have exactly four states: IDLE (stable low), CHK_HI (qualifying a rise), HIGH (stable high) and CHK_LO (qualifying a fall).
REQ-012 In IDLE, if sync_in=1, the FSM SHALL go to CHK_HI and load cnt to 1; otherwise it SHALL stay in IDLE with cnt=0.
REQ-013 In CHK_HI, if sync_in=0, the FSM SHALL return to IDLE and clear cnt, with no pulse.
REQ-014 In CHK_HI, if sync_in=1 and cnt<DB_CYCLES-1, the FSM SHALL increment cnt.
REQ-015 In CHK_HI, if sync_in=1 and cnt=DB_CYCLES-1, the FSM SHALL go to HIGH, clear cnt and set db_level to 1.
REQ-016 A press SHALL be accepted only after DB_CYCLES consecutive clock edges sample sync_in=1.
REQ-017 In HIGH, if sync_in=0, the FSM SHALL go to CHK_LO with cnt=1; otherwise it SHALL stay in HIGH.
REQ-018 In CHK_LO, if sync_in=1, the FSM SHALL return to HIGH, clear cnt and keep db_level=1, with no pulse.
REQ-019 In CHK_LO, if sync_in=0 and cnt<DB_CYCLES-1, the FSM SHALL increment cnt.
REQ-020 In CHK_LO, if sync_in=0 and cnt=DB_CYCLES-1, the FSM SHALL go to IDLE, clear cnt and clear db_level.
REQ-021 db_level SHALL change only on the CHK_HI->HIGH and CHK_LO->IDLE transitions.
REQ-022 press_pulse SHALL be 1 for exactly the one cycle immediately following the CHK_HI->HIGH edge, and 0 at all other times.
REQ-023 release_pulse SHALL be 1 for exactly the one cycle immediately following the CHK_LO->IDLE edge, and 0 at all other times.
REQ-024 press_pulse and release_pulse SHALL never be 1 in the same cycle.
REQ-025 A press SHALL produce at least DB_CYCLES cycles of separation between its press_pulse and the matching release_pulse.
REQ-026 Holding sync_in=1 indefinitely SHALL produce exactly one press_pulse, with no auto-repeat.
REQ-027 press_cnt SHALL increment by 1 on the same edge that sets press_pulse.
REQ-028 press_cnt SHALL wrap modulo 8 (7 -> 0) with no saturation flag.
REQ-029 cnt SHALL never exceed DB_CYCLES-1.
REQ-030 cnt SHALL never wrap, for any legal DB_CYCLES.
REQ-031 Glitches shorter than DB_CYCLES cycles, in either direction, SHALL leave db_level, the pulses and press_cnt unchanged.

Reset
REQ-032 When rst_n=0 is sampled on a clk rising edge, the block SHALL set the state to IDLE and cnt, db_level, press_pulse, release_pulse and press_cnt all to 0.
REQ-033 Reset SHALL override every transition, including mid-CHK_HI and mid-CHK_LO, and SHALL discard any pending pulse.
REQ-034 If sync_in=1 while rst_n is released, the block SHALL qualify the press from cnt=0 and emit press_pulse DB_CYCLES cycles after the first non-reset edge.

Verification (DB_CYCLES=4)
REQ-035 The bench SHALL check a clean press: sync_in 0->1 held 10 cycles -> db_level and press_pulse rise 4 edges after the first high sample, press_pulse is high for 1 cycle, press_cnt=1.
REQ-036 The bench SHALL check a rise glitch: sync_in high for 3 cycles then low -> no press_pulse, db_level=0, press_cnt unchanged.
REQ-037 The bench SHALL check release bounce: from HIGH, sync_in low 2 cycles, high 1 cycle, then low 4 cycles -> a single release_pulse after the final 4th low sample, db_level stays 1 until then.
REQ-038 The bench SHALL check press_cnt wrap: 9 clean press/release pairs -> press_cnt sequence 1..7, 0, 1.
REQ-039 The bench SHALL check reset mid-qualification: rst_n=0 while in CHK_HI with cnt=2 -> all outputs 0 on the next edge; sync_in held 1 after release -> press_pulse 4 cycles after release.
REQ-040 The bench SHALL check stuck-high: sync_in=1 for 100 cycles -> exactly one press_pulse, no release_pulse.
